// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the cipher core.
package aes_pkg;

    localparam int unsigned LENGTH = 128;
    localparam int unsigned Nb     = 4;
    localparam int unsigned Nr     = 10;
    localparam int unsigned KS_W   = Nb * (Nr + 1) * 32;
    localparam int unsigned RND_W  = 4;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Round key r as a 128-bit block with w[4r] in the most significant column.
    function automatic logic [LENGTH-1:0] round_key(input logic [KS_W-1:0] ks,
                                                    input logic [RND_W-1:0] r);
        logic [LENGTH-1:0] rk;
        rk = '0;
        for (int unsigned c = 0; c < Nb; c++) begin
            rk[LENGTH-1-32*c -: 32] = ks[32*(Nb*32'(r)+c) +: 32];
        end
        return rk;
    endfunction

endpackage

// File: rtl/S_box.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module S_box
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv_c;

    always_comb begin
        inv_c    = gf_inv(in_byte);
        out_byte = inv_c
                 ^ {inv_c[6:0], inv_c[7]}
                 ^ {inv_c[5:0], inv_c[7:6]}
                 ^ {inv_c[4:0], inv_c[7:5]}
                 ^ {inv_c[3:0], inv_c[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [LENGTH-1:0] state_in,
    input  logic [LENGTH-1:0] round_key,
    input  logic              final_round,
    output logic [LENGTH-1:0] state_out_c
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        S_box u_sbox (
            .in_byte  (state_in[LENGTH-1-8*i -: 8]),
            .out_byte (sb[i])
        );
    end

    // Row k of column c takes the byte from column (c+k) mod 4.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                sr[4*c+k] = sb[4*((c+k)%4)+k];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
            mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
        end
    end

    always_comb begin
        state_out_c = '0;
        for (int i = 0; i < 16; i++) begin
            state_out_c[LENGTH-1-8*i -: 8] = (final_round ? sr[i] : mc[i])
                                           ^ round_key[LENGTH-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock behind a valid/ready handshake.
module aes_cipher_core
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] plaintext,
    input  logic [KS_W-1:0]   key_schedule,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] ciphertext
);

    fsm_e              fsm_q, fsm_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic [LENGTH-1:0] st_q, st_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [RND_W-1:0]  rk_idx_c;
    logic [LENGTH-1:0] rk_c;
    logic [LENGTH-1:0] rnd_c;
    logic              final_c;

    // Key 0 is used for the initial whitening in IDLE, key r during round r.
    always_comb begin
        rk_idx_c = (fsm_q == ROUND) ? round_q : '0;
        rk_c     = round_key(key_schedule, rk_idx_c);
        final_c  = (round_q == RND_W'(Nr));
    end

    aes_round u_round (
        .state_in    (st_q),
        .round_key   (rk_c),
        .final_round (final_c),
        .state_out_c (rnd_c)
    );

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        st_d    = st_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    fsm_d   = ROUND;
                    round_d = RND_W'(1);
                    st_d    = plaintext ^ rk_c;
                end
            end
            ROUND: begin
                st_d    = rnd_c;
                round_d = round_q + RND_W'(1);
                if (final_c) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state's decode.
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            st_q        <= st_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = st_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core against a byte-array AES-128 reference model.
module tb_aes_cipher_core;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  plaintext;
    logic [1407:0] key_schedule;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  ciphertext;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] sbox_tbl [256];

    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_cipher_core dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plaintext    (plaintext),
        .key_schedule (key_schedule),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ciphertext   (ciphertext)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] acc;
        x = a; y = b; acc = 8'h00;
        while (y != 8'h00) begin
            if (y[0]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return acc;
    endfunction

    function automatic logic [7:0] mix_coef(input int row, input int col);
        int d;
        d = (col - row + 4) % 4;
        return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
    endfunction

    // Walks generator 3 and its inverse together to fill the table.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tbl[0] = 8'h63;
    endtask

    task automatic expand_key(input logic [127:0] key, output logic [1407:0] ks);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    endtask

    task automatic model_encrypt(input logic [127:0] key, input logic [127:0] pt,
                                 output logic [127:0] ct);
        logic [1407:0] ks;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [7:0]    acc;
        expand_key(key, ks);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++) t[4*c+k] = s[4*((c+k)%4)+k];
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++) begin
                        if (r < 10) begin
                            acc = 8'h00;
                            for (int j = 0; j < 4; j++) acc = acc ^ mul(t[4*c+j], mix_coef(k, j));
                            s[4*c+k] = acc;
                        end else begin
                            s[4*c+k] = t[4*c+k];
                        end
                    end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ ks[32*(4*r + i/4) + 24 - 8*(i%4) +: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] ks;
        expand_key(key, ks);
        key_schedule = ks;
        plaintext    = pt;
        in_valid     = 1'b1;
        for (int k = 0; k < 40 && !in_ready; k++) step();
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key_schedule = '0;
        step(); step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ciphertext !== 128'h0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b ct=%h, want 1 0 0", in_ready, out_valid, ciphertext);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_vector(input string name, input logic [127:0] key,
                               input logic [127:0] pt, input logic [127:0] ct_exp);
        int   lat;
        logic busy_bad;
        out_ready = 1'b0;
        send(key, pt);
        lat = 0; busy_bad = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) busy_bad = 1'b1;
            step();
            lat++;
        end
        n_tests++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, want 10", name, lat);
        end
        n_tests++;
        if (ciphertext !== ct_exp) begin
            n_fail++;
            $display("FAIL %s ct: got %h, want %h", name, ciphertext, ct_exp);
        end
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL %s busy in_ready: got 1 while busy, want 0", name);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic bad;
        int   extra;
        out_ready = 1'b0;
        send(K_B, PT_B);
        wait_out(lat);
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ciphertext !== CT_B) bad = 1'b1;
            step();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure hold: ov=%b ir=%b ct=%h, want 1 0 %h", out_valid, in_ready, ciphertext, CT_B);
        end
        out_ready = 1'b1;
        step();
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) extra++;
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (extra != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure release: extra out_valid cycles=%0d in_ready=%b, want 0 1", extra, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1407:0] ks_b;
        logic [1407:0] ks_c;
        logic [127:0]  got [2];
        int            stamp [2];
        int            nseen;
        expand_key(K_B, ks_b);
        expand_key(K_C1, ks_c);
        key_schedule = ks_b; plaintext = PT_B;
        in_valid = 1'b1; out_ready = 1'b1;
        nseen = 0;
        got[0] = '0; got[1] = '0; stamp[0] = 0; stamp[1] = 0;
        for (int g = 0; g < 80 && nseen < 2; g++) begin
            if (out_valid) begin
                got[nseen]   = ciphertext;
                stamp[nseen] = cyc;
                nseen++;
                key_schedule = ks_c;
                plaintext    = PT_C1;
                if (nseen == 2) in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (nseen != 2 || got[0] !== CT_B || got[1] !== CT_C1) begin
            n_fail++;
            $display("FAIL b2b data: n=%0d got %h %h, want %h %h", nseen, got[0], got[1], CT_B, CT_C1);
        end
        n_tests++;
        if (stamp[1] - stamp[0] != 12) begin
            n_fail++;
            $display("FAIL b2b spacing: got %0d cycles, want 12", stamp[1] - stamp[0]);
        end
    endtask

    task automatic test_busy_pulse();
        int lat;
        int extra;
        out_ready = 1'b0;
        send(K_C1, PT_C1);
        step(); step(); step();
        plaintext = 128'hdeadbeef_01234567_89abcdef_0badf00d;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        wait_out(lat);
        n_tests++;
        if (ciphertext !== CT_C1 || lat !== 6) begin
            n_fail++;
            $display("FAIL busy pulse: ct=%h lat=%0d, want %h 6", ciphertext, lat, CT_C1);
        end
        out_ready = 1'b1;
        step();
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) extra++;
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL busy pulse extra: got %0d output cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic spurious;
        out_ready = 1'b1;
        send(K_B, PT_B);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ciphertext !== 128'h0) begin
            n_fail++;
            $display("FAIL mid reset: ir=%b ov=%b ct=%h, want 1 0 0", in_ready, out_valid, ciphertext);
        end
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) spurious = 1'b1;
            step();
        end
        n_tests++;
        if (spurious) begin
            n_fail++;
            $display("FAIL mid reset discard: got out_valid=1, want 0");
        end
        out_ready = 1'b0;
        test_vector("post_reset", K_B, PT_B, CT_B);
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] exp_ct;
        logic [127:0] got;
        logic         xfer;
        logic         done;
        int           guard;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            model_encrypt(key, pt, exp_ct);
            in_valid = 1'b0; out_ready = 1'b0;
            for (int d = $urandom_range(0, 3); d > 0; d--) step();
            send(key, pt);
            done = 1'b0; guard = 0; got = '0;
            while (!done && guard < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
                plaintext = {$urandom, $urandom, $urandom, $urandom};
                xfer = out_valid && out_ready;
                if (xfer) got = ciphertext;
                step();
                guard++;
                if (xfer) done = 1'b1;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            n_tests++;
            if (!done || got !== exp_ct) begin
                n_fail++;
                $display("FAIL random[%0d]: done=%b got %h, want %h", n, done, got, exp_ct);
            end
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d] duplicate: out_valid=%b, want 0", n, out_valid);
            end
        end
    endtask

    initial begin
        build_sbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key_schedule = '0;
        test_reset();
        test_vector("fips_b", K_B, PT_B, CT_B);
        test_vector("fips_c1", K_C1, PT_C1, CT_C1);
        test_backpressure();
        test_back_to_back();
        test_busy_pulse();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES-128 encryption engine: accepts one 128-bit plaintext block, runs the initial AddRoundKey plus Nr rounds at one round per clock, and returns the ciphertext under a valid/ready handshake. It sits directly downstream of `key_expansion` and consumes its flat 44-word `key_schedule` bus unregistered. It feeds the record-encryption layer of the secure channel.

## Interface
- `LENGTH`, 128, block and key width in bits.
- `Nb`, 4, columns per state.
- `Nr`, 10, number of rounds.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `plaintext` is valid.
- `in_ready` output 1: core is idle and can accept a block.
- `plaintext` input LENGTH: input block; byte 0 is in bits [127:120].
- `key_schedule` input Nb*(Nr+1)*32: word w[i] is at bits [32*i +: 32]; w0 is the most significant key word.
- `out_valid` output 1: `ciphertext` is valid.
- `out_ready` input 1: downstream accepts `ciphertext`.
- `ciphertext` output LENGTH: result block, same byte order as `plaintext`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - ROUND: busy, 4-bit `round` counter active.
  - DONE: `out_valid`=1.
- IDLE -> ROUND when `in_valid && in_ready`:
  - `state <= plaintext ^ {w0,w1,w2,w3}`.
  - `round <= 1`.
- ROUND, each cycle, for round r:
  - `state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), r)`.
  - MixColumns is skipped when r == Nr.
  - `round` increments.
  - When r == Nr, go to DONE.
- Round key r is w[4r..4r+3]. State column c is bits [127-32c -: 32] and is XORed with w[4r+c].
- ShiftRows: row k (byte k of each column) rotates left by k columns.
- MixColumns uses the standard matrix {02,03,01,01} with xtime reduction by 0x1b. All arithmetic is in GF(2^8) and byte-wide; there are no carries.
- DONE -> IDLE when `out_ready`=1. `ciphertext` holds the state register and stays stable while `out_valid && !out_ready`.
- `key_schedule` and `plaintext` are not captured beyond the first XOR. Upstream holds `key_schedule` stable from acceptance until `out_valid`. The bench asserts this.
- A new block is accepted only from IDLE. There is no overlap of consecutive blocks.
- `rst` during any state:
  - Next state is IDLE and `round` = 0.
  - The state register is cleared to 0.
  - Any in-flight block is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `ciphertext`=128'h0.
- The acceptance edge is E0. Round edges are E1..E10. `out_valid` rises in the cycle after E10, i.e. Nr clocks after acceptance.
- With `out_ready` tied high, `out_valid` lasts exactly one cycle and `in_ready` returns the cycle after that. Throughput is one block per Nr+2 cycles.
- `in_ready` is a pure function of the FSM state. It has no combinational path from `in_valid` or `out_ready`.
- `in_valid` asserted while busy is ignored. Upstream must hold it until `in_ready`.
- The combinational path per cycle is one round: SubBytes, ShiftRows, MixColumns, XOR.

## Structure
- Shared package `aes_pkg`:
  - `Nb`, `Nr`, `LENGTH` constants.
  - FSM state enum {IDLE, ROUND, DONE}.
  - `xtime` and `gmul2`/`gmul3` functions.
  - Round-key slice helper.
- Sub-module `aes_round`: one combinational round.
  - Inputs: state, round key, `final_round` flag.
  - Built from 16 instances of the existing `S_box` plus shift-rows wiring, 4 MixColumns columns, and the XOR.
- Top level: FSM, round counter, state register, round-key mux over `key_schedule`.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, `out_valid` exactly 10 clocks after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold `out_ready`=0 for 7 cycles after `out_valid` -> `ciphertext` stable, `in_ready`=0 throughout, one transfer on release.
- Back-to-back: `in_valid` held high with both vectors queued and `out_ready`=1 -> both correct ciphertexts in order, 12 cycles apart; an `in_valid` pulse while busy is ignored.
- Reset mid-operation: assert `rst` on E5 -> next cycle `in_ready`=1, `out_valid`=0, `ciphertext`=0; the following App. B block encrypts correctly.
- Randomised: 1000 random key/pt pairs vs. a software AES model, with random `in_valid`/`out_ready` stalls -> all match, no drops or duplicates.
